// File: rtl/tl_pkg.sv
// tl_pkg: phase states, lamp type and duration clamp shared by traffic_light_ctrl.
package tl_pkg;
    typedef enum logic [2:0] {
        ALLRED_A, MAIN_GREEN, MAIN_YELLOW, ALLRED_B, SIDE_GREEN, SIDE_YELLOW, FLASH
    } tl_state_t;
    typedef struct packed {
        logic r;
        logic y;
        logic g;
    } lamp_t;
    function automatic int dur_clamp(input int d);
        return d < 1 ? 1 : d;
    endfunction
endpackage

// File: rtl/tl_tick_gen.sv
// tl_tick_gen: prescaler emitting a one-cycle tick every TICK_DIV enabled cycles.
module tl_tick_gen
    import tl_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);
    logic [CNT_W-1:0] pre;
    assign tick = enable && pre == CNT_W'(dur_clamp(TICK_DIV) - 1);
    always_ff @(posedge clk) begin
        if (rst) pre <= '0;
        else if (tick) pre <= '0;
        else if (enable) pre <= pre + 1'b1;
    end
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: main/side intersection controller with all-red clearance and pedestrian request.
// Define TL_FLASH_EN to add the flash input and the blinking FLASH state.
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int TICK_DIV     = 1,
    parameter int CNT_W        = 32,
    parameter int MAIN_GREEN_T = 10,
    parameter int MIN_GREEN_T  = 3,
    parameter int SIDE_GREEN_T = 5,
    parameter int YELLOW_T     = 2,
    parameter int ALLRED_T     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
`ifdef TL_FLASH_EN
    input  logic flash,
`endif
    input  logic ped_req,
    output logic main_red,
    output logic main_yellow,
    output logic main_green,
    output logic side_red,
    output logic side_yellow,
    output logic side_green,
    output logic ped_walk,
    output logic ped_pending
);
    localparam int MG = dur_clamp(MAIN_GREEN_T);
    localparam int MN = dur_clamp(MIN_GREEN_T);
    localparam int SG = dur_clamp(SIDE_GREEN_T);
    localparam int YL = dur_clamp(YELLOW_T);
    localparam int AR = dur_clamp(ALLRED_T);

    tl_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    lamp_t            main_l, side_l, main_n, side_n;
    logic             tick, expire, early, lat_set, ped_lat, lat_n, walk, walk_n, fl_on;
    int               dur;
`ifdef TL_FLASH_EN
    logic             blink, blink_n;
`endif

    tl_tick_gen #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick)
    );

    always_comb begin
        expire  = tick && cnt == '0;
        // this tick is the one that brings elapsed main-green ticks up to MIN_GREEN_T
        early   = tick && ped_lat && (CNT_W'(MG) - cnt) >= CNT_W'(MN);
        lat_set = ped_lat || ped_req;
        state_n = state;
        case (state)
            ALLRED_A:    state_n = expire ? MAIN_GREEN : state;
            MAIN_GREEN:  state_n = (expire || early) ? MAIN_YELLOW : state;
            MAIN_YELLOW: state_n = expire ? ALLRED_B : state;
            ALLRED_B:    state_n = expire ? SIDE_GREEN : state;
            SIDE_GREEN:  state_n = expire ? SIDE_YELLOW : state;
            SIDE_YELLOW: state_n = expire ? ALLRED_A : state;
            default:     state_n = ALLRED_A;
        endcase
`ifdef TL_FLASH_EN
        if (flash) state_n = FLASH;
        blink_n = state == FLASH ? blink ^ tick : 1'b1;
        fl_on   = state_n == FLASH && blink_n;
`else
        fl_on   = 1'b0;
`endif
        dur = state_n == MAIN_GREEN ? MG : state_n == SIDE_GREEN ? SG :
              (state_n == MAIN_YELLOW || state_n == SIDE_YELLOW) ? YL : AR;
        cnt_n  = state_n != state ? CNT_W'(dur - 1) : tick ? cnt - 1'b1 : cnt;
        // the request is consumed on side-green entry and ignored while it lasts
        lat_n  = (state == SIDE_GREEN || state_n == SIDE_GREEN) ? 1'b0 : lat_set;
        walk_n = state_n == SIDE_GREEN && (state == SIDE_GREEN ? walk : lat_set);
        main_n.r = state_n inside {ALLRED_A, ALLRED_B, SIDE_GREEN, SIDE_YELLOW};
        main_n.y = state_n == MAIN_YELLOW || fl_on;
        main_n.g = state_n == MAIN_GREEN;
        side_n.r = state_n inside {ALLRED_A, ALLRED_B, MAIN_GREEN, MAIN_YELLOW} || fl_on;
        side_n.y = state_n == SIDE_YELLOW;
        side_n.g = state_n == SIDE_GREEN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ALLRED_A;
            cnt     <= CNT_W'(AR - 1);
            ped_lat <= 1'b0;
            walk    <= 1'b0;
            main_l  <= 3'b100;
            side_l  <= 3'b100;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ped_lat <= lat_n;
            walk    <= walk_n;
            main_l  <= main_n;
            side_l  <= side_n;
        end
    end

`ifdef TL_FLASH_EN
    always_ff @(posedge clk) begin
        blink <= rst ? 1'b0 : blink_n;
    end
`endif

    assign main_red    = main_l.r;
    assign main_yellow = main_l.y;
    assign main_green  = main_l.g;
    assign side_red    = side_l.r;
    assign side_yellow = side_l.y;
    assign side_green  = side_l.g;
    assign ped_walk    = walk;
    assign ped_pending = ped_lat;
endmodule
